// File: rtl/ramb4_arb_pkg.sv
// Shared types and defaults for the RAMB4 8-bit port arbiter.
package ramb4_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_RUN
    } arb_state_e;

    typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; the last-grant register lives in the caller.
module rr_pick2
    import ramb4_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_idx_t   last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt_o = (last_gnt_i == 1'b1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ramb4_s8_port_arb.sv
// Round-robin arbiter sharing the 8-bit port B of a 512x8 RAMB4 between two requesters.
// Define RAMB4_ARB_CLEAR_EN to zero-fill the whole RAM after every reset before serving.
module ramb4_s8_port_arb
    import ramb4_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned CLR_DEPTH = 512
) (
    input  logic              CLKA,
    input  logic              RSTB,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,

    output logic              busy
);

    if (CLR_DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("CLR_DEPTH must equal 2**ADDR_W");
    end

    logic              run;
    logic              clr_active;
    logic [ADDR_W-1:0] clr_addr;

`ifdef RAMB4_ARB_CLEAR_EN
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == ADDR_W'(CLR_DEPTH - 1)) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end
    end

    // Outputs stay quiet while reset is held so the reset values are visible on the pins.
    assign clr_active = (state_q == ST_CLEAR) && !RSTB;
    assign run        = (state_q == ST_RUN) && !RSTB;
    assign busy       = (state_q == ST_CLEAR);
    assign clr_addr   = clr_cnt_q;
`else
    assign clr_active = 1'b0;
    assign run        = !RSTB;
    assign busy       = 1'b0;
    assign clr_addr   = '0;
`endif

    logic [1:0] req_valid;
    logic [1:0] gnt;
    req_idx_t   last_gnt_q, last_gnt_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;

    assign req_valid = {req1_valid, req0_valid} & {2{run}};

    rr_pick2 u_pick (
        .valid_i    (req_valid),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt[1]) begin
            last_gnt_d = 1'b1;
        end else if (gnt[0]) begin
            last_gnt_d = 1'b0;
        end
        rsp_valid_d = gnt & ~{req1_we, req0_we};
    end

    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            last_gnt_q  <= 1'b1;
            rsp_valid_q <= 2'b00;
        end else begin
            last_gnt_q  <= last_gnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (clr_active) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (gnt[0]) begin
            ram_en   = 1'b1;
            ram_we   = req0_we;
            ram_addr = req0_addr;
            ram_di   = req0_wdata;
        end else if (gnt[1]) begin
            ram_en   = 1'b1;
            ram_we   = req1_we;
            ram_addr = req1_addr;
            ram_di   = req1_wdata;
        end
    end

    assign ram_rst    = 1'b0;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    // DOB already carries the registered read; the strobe marks which requester owns it.
    assign rsp0_rdata = ram_do;
    assign rsp1_rdata = ram_do;

endmodule

// File: tb/tb_ramb4_s8_port_arb.sv
// Scoreboard bench for ramb4_s8_port_arb with a behavioural RAM and reference model.
// Honours RAMB4_ARB_CLEAR_EN to match the DUT build.
`timescale 1ns/1ps
module tb_ramb4_s8_port_arb;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int DEPTH = 512;

    logic          CLKA = 1'b0;
    logic          RSTB = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          ram_en, ram_we, ram_rst, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;

    always #5 CLKA = ~CLKA;

    ramb4_s8_port_arb #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLR_DEPTH (DEPTH)
    ) dut (
        .CLKA       (CLKA),
        .RSTB       (RSTB),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_rst    (ram_rst),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_do     (ram_do),
        .busy       (busy)
    );

    // Write-first synchronous RAM standing in for port B.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_do_q;
    always @(posedge CLKA) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do_q      <= ram_di;
            end else begin
                ram_do_q <= mem[ram_addr];
            end
        end
    end
    assign ram_do = ram_do_q;

    function automatic logic [DW-1:0] init_val(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_last;
    int            wait_n [2];
    int            gnt_log[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    logic [1:0]    p_valid;
    logic          p_we    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];

    always @(posedge CLKA) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        n = (idx == 0) ? q0.size() : q1.size();
        if (v) begin
            if (n == 0) begin
                chk($sformatf("rsp%0d_valid_unexpected", idx), 32'(v), 32'(0));
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rsp%0d_latency", idx), 32'(cyc), 32'(e.due));
                chk($sformatf("rsp%0d_rdata", idx), 32'(d), 32'(e.data));
            end
        end else if (n != 0) begin
            e = (idx == 0) ? q0[0] : q1[0];
            if (e.due <= cyc) begin
                chk($sformatf("rsp%0d_valid_missing", idx), 32'(v), 32'(1));
                if (idx == 0) void'(q0.pop_front());
                else          void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge CLKA) begin
        mon(0, rsp0_valid, rsp0_rdata);
        mon(1, rsp1_valid, rsp1_rdata);
    end

    task automatic set_req(input int idx, input logic we, input int addr, input int data);
        p_valid[idx] = 1'b1;
        p_we[idx]    = we;
        p_addr[idx]  = AW'(addr);
        p_wdata[idx] = DW'(data);
    endtask

    // One cycle: drive pending requests, predict the grant, check, update the model.
    task automatic cycle();
        logic has_g, gi;
        exp_t e;
        req0_valid = p_valid[0]; req0_we = p_we[0]; req0_addr = p_addr[0]; req0_wdata = p_wdata[0];
        req1_valid = p_valid[1]; req1_we = p_we[1]; req1_addr = p_addr[1]; req1_wdata = p_wdata[1];
        @(negedge CLKA);
        has_g = (p_valid != 2'b00);
        if (p_valid == 2'b11) gi = (ref_last == 1) ? 1'b0 : 1'b1;
        else                  gi = p_valid[1];
        chk("ready", 32'({req1_ready, req0_ready}), has_g ? 32'(1 << gi) : 32'(0));
        chk("busy", 32'(busy), 32'(0));
        chk("ram_rst", 32'(ram_rst), 32'(0));
        if (has_g) begin
            chk("ram_drive", 32'({ram_en, ram_we, ram_addr, ram_di}),
                32'({1'b1, p_we[gi], p_addr[gi], p_wdata[gi]}));
            checks++;
            if (wait_n[gi] > 1) begin
                errors++;
                $display("FAIL wait_bound req%0d waited=%0d required<=1", gi, wait_n[gi]);
            end
            if (p_we[gi]) begin
                ref_mem[p_addr[gi]] = p_wdata[gi];
            end else begin
                e.due  = cyc + 1;
                e.data = ref_mem[p_addr[gi]];
                if (gi == 1'b0) q0.push_back(e);
                else            q1.push_back(e);
            end
            ref_last    = int'(gi);
            p_valid[gi] = 1'b0;
            wait_n[gi]  = 0;
            gnt_log.push_back(int'(gi));
            if (p_valid[~gi]) wait_n[~gi]++;
        end else begin
            chk("ram_idle", 32'({ram_en, ram_we, ram_addr, ram_di}), 32'(0));
        end
        @(posedge CLKA);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && p_valid != 2'b00; i++) cycle();
        if (p_valid != 2'b00) begin
            chk("grant_timeout", 32'({req1_ready, req0_ready}), 32'(p_valid));
            p_valid = 2'b00;
        end
        cycle();
        cycle();
    endtask

    // Two reset cycles with a read offered, which must be neither granted nor answered.
    task automatic reset_phase();
        RSTB       = 1'b1;
        p_valid    = 2'b00;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 9'h010;
        req1_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLKA);
            @(negedge CLKA);
            chk("rst_ready", 32'({req1_ready, req0_ready}), 32'(0));
            chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'(0));
            chk("rst_ram", 32'({ram_en, ram_we, ram_addr, ram_di, ram_rst}), 32'(0));
`ifdef RAMB4_ARB_CLEAR_EN
            chk("rst_busy", 32'(busy), 32'(1));
`else
            chk("rst_busy", 32'(busy), 32'(0));
`endif
        end
        q0.delete();
        q1.delete();
        ref_last  = 1;
        wait_n[0] = 0;
        wait_n[1] = 0;
        @(posedge CLKA);
        #1;
        RSTB       = 1'b0;
        req0_valid = 1'b0;
    endtask

`ifdef RAMB4_ARB_CLEAR_EN
    // Walks the clear sequence with both requesters asking; stops early at stop_at.
    task automatic clear_check(input int stop_at);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLKA);
            chk("clr_busy", 32'(busy), 32'(1));
            chk("clr_ready", 32'({req1_ready, req0_ready}), 32'(0));
            chk("clr_ram", 32'({ram_en, ram_we, ram_addr, ram_di}), 32'({2'b11, AW'(i), 8'h00}));
            @(posedge CLKA);
            #1;
            if (i == stop_at) return;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        p_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end

        reset_phase();
`ifdef RAMB4_ARB_CLEAR_EN
        clear_check(200);
        reset_phase();
        clear_check(-1);
        set_req(0, 1'b0, 'h1FF, 0);
        drain();
`else
        set_req(0, 1'b1, 'h0FF, 'h3C);
        cycle();
        set_req(0, 1'b0, 'h0FF, 0);
        drain();
`endif

        set_req(0, 1'b1, 'h010, 'hA5);
        cycle();
        set_req(0, 1'b0, 'h010, 0);
        drain();

        set_req(0, 1'b1, 'h000, 'h11);
        cycle();
        set_req(1, 1'b1, 'h001, 'h22);
        cycle();
        gnt_log.delete();
        for (int k = 0; k < 4; k++) begin
            if (!p_valid[0]) set_req(0, 1'b0, 'h000, 0);
            if (!p_valid[1]) set_req(1, 1'b0, 'h001, 0);
            cycle();
        end
        drain();
        for (int k = 0; k < 4; k++) chk("tie_order", 32'(gnt_log[k]), 32'(k % 2));

        set_req(0, 1'b1, 'h020, 'h5A);
        set_req(1, 1'b1, 'h021, 'hC3);
        cycle();
        cycle();
        set_req(0, 1'b0, 'h021, 0);
        set_req(1, 1'b0, 'h020, 0);
        drain();

        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i] && $urandom_range(0, 99) < 70) begin
                    set_req(i, 1'($urandom), ($urandom_range(0, 1) == 1) ?
                            int'($urandom_range(0, 15)) : int'($urandom_range(0, DEPTH - 1)),
                            int'($urandom_range(0, 255)));
                end
            end
            cycle();
        end
        drain();
        chk("rsp0_outstanding", 32'(q0.size()), 32'(0));
        chk("rsp1_outstanding", 32'(q1.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d expected run to finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
